// File: rtl/tvla_sequencer.sv
// Fixed-vs-random TVLA capture sequencer: paces traces, drives the scope
// trigger and chains random plaintexts from the previous ciphertext.
module tvla_sequencer #(
    parameter int unsigned  NUM_TRACES = 1000,
    parameter int unsigned  GAP_CYCLES = 1000,
    parameter int unsigned  TRIG_LEAD  = 4,
    parameter int unsigned  TIMEOUT    = 255,
    parameter logic [15:0]  LFSR_SEED  = 16'hACE1,
    parameter logic [127:0] FIXED_PT   = 128'h0,
    parameter logic [127:0] RAND_SEED  = 128'hDA39A3EE5E6B4B0D3255BFEF95601890,
    parameter logic [127:0] KEY        = 128'h000102030405060708090A0B0C0D0E0F
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         aes_ready,
    output logic         aes_start,
    output logic [127:0] aes_pt,
    output logic [127:0] aes_key,
    input  logic         aes_valid,
    input  logic [127:0] aes_ct,
    output logic         trigger_pin,
    output logic         output_fix,
    output logic         done_signal,
    output logic         timeout_err,
    output logic [15:0]  trace_count,
    output logic [127:0] ct_sig
);

    typedef enum logic [2:0] {
        IDLE, GAP, ARM, LAUNCH, BUSY, POST, DONE, ERR
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [15:0]    lfsr_q, lfsr_d, lfsr_step;
    logic [127:0]   rand_q, rand_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   pt_q, pt_d;
    logic           fix_q, fix_d;
    logic [15:0]    tc_q, tc_d;
    logic [127:0]   sig_q, sig_d;

    assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                        lfsr_q[15:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            rand_q  <= RAND_SEED;
            ct_q    <= '0;
            pt_q    <= '0;
            fix_q   <= 1'b0;
            tc_q    <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
            ct_q    <= ct_d;
            pt_q    <= pt_d;
            fix_q   <= fix_d;
            tc_q    <= tc_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        rand_d    = rand_q;
        ct_d      = ct_q;
        pt_d      = pt_q;
        fix_d     = fix_q;
        tc_d      = tc_q;
        sig_d     = sig_q;
        aes_start = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    tc_d   = '0;
                    sig_d  = '0;
                    lfsr_d = LFSR_SEED;
                    rand_d = RAND_SEED;
                    cnt_d  = '0;
                    if (NUM_TRACES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
                        fix_d   = LFSR_SEED[0];
                        pt_d    = LFSR_SEED[0] ? FIXED_PT : RAND_SEED;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_CYCLES - 1) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ARM: begin
                if (cnt_q == TRIG_LEAD - 1) begin
                    state_d = LAUNCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            LAUNCH: begin
                // Never launch while reset is being applied
                aes_start = aes_ready & ~RST;
                if (aes_ready) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (aes_valid) begin
                    ct_d    = aes_ct;
                    state_d = POST;
                end else if (cnt_q == TIMEOUT - 1) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            POST: begin
                tc_d   = tc_q + 16'd1;
                sig_d  = sig_q ^ ct_q;
                lfsr_d = lfsr_step;
                cnt_d  = '0;
                if (!fix_q) rand_d = ct_q;
                if (tc_d == 16'(NUM_TRACES)) begin
                    state_d = DONE;
                end else begin
                    state_d = GAP;
                    fix_d   = lfsr_step[0];
                    pt_d    = lfsr_step[0] ? FIXED_PT : rand_d;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign aes_pt      = pt_q;
    assign aes_key     = KEY;
    assign output_fix  = fix_q;
    assign trace_count = tc_q;
    assign ct_sig      = sig_q;
    assign trigger_pin = (state_q == ARM) || (state_q == LAUNCH) ||
                         (state_q == BUSY);
    assign done_signal = (state_q == DONE);
    assign timeout_err = (state_q == ERR);

endmodule
